// File: rtl/iscas_bist_ctrl_if.sv
// BIST controller <-> wrapper bundle: run control, pattern out, response in, signature out.
// Master side drives start/po/golden and observes the controller; slave side is the controller.
interface iscas_bist_ctrl_if #(
  parameter int PI_W = 3,
  parameter int PO_W = 6
);
  logic            start;
  logic            busy;
  logic            done;
  logic [PI_W-1:0] pat;
  logic [PO_W-1:0] po;
  logic [15:0]     golden;
  logic [15:0]     sig;
  logic            pass;

  modport master (
    output start, po, golden,
    input  busy, done, pat, sig, pass
  );

  modport slave (
    input  start, po, golden,
    output busy, done, pat, sig, pass
  );
endinterface

// File: rtl/iscas_bist_ctrl.sv
// LFSR pattern source + MISR compactor for ISCAS89 BIST; N_PAT+LATENCY cycles from START to DONE.
// No backpressure: START is accepted only in IDLE/DONE and ignored while a run is in flight.
module iscas_bist_ctrl #(
  parameter int          PI_W    = 3,
  parameter int          PO_W    = 6,
  parameter int          N_PAT   = 256,
  parameter int          LATENCY = 1,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic              ck,
  input logic              rn,
  iscas_bist_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int          PIPE_W = (LATENCY == 0) ? 1 : LATENCY;
  localparam logic [15:0] LAST   = 16'(N_PAT - 1);
  localparam logic [2:0]  DLAST  = 3'(LATENCY - 1);

  state_t            state;
  logic [15:0]       lfsr;
  logic [15:0]       misr;
  logic [15:0]       cnt;
  logic [2:0]        dcnt;
  logic [PIPE_W-1:0] vpipe;
  logic              arm;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic              run;
  logic              cap;
  logic              go;
  logic              last_pat;
  logic [15:0]       lfsr_nxt;
  logic [15:0]       misr_nxt;

  assign run      = (state == S_RUN);
  // Each RUN cycle launches a valid token; it reaches the pipe end when that pattern's response is on po.
  assign cap      = (LATENCY == 0) ? run : vpipe[PIPE_W-1];
  assign last_pat = (cnt == LAST);
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign misr_nxt = cap ? ({misr[0] ^ misr[2] ^ misr[3] ^ misr[5], misr[15:1]} ^ 16'(bus.po))
                        : misr;
  // arm is low for the first edge after reset release, so a START overlapping deassertion is dropped.
  assign go       = bus.start && arm && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state  <= S_IDLE;
      lfsr   <= SEED;
      misr   <= 16'h0000;
      cnt    <= 16'h0000;
      dcnt   <= 3'd0;
      vpipe  <= '0;
      arm    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      arm      <= 1'b1;
      vpipe[0] <= run;
      for (int i = 1; i < PIPE_W; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      misr <= misr_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            lfsr   <= SEED;
            misr   <= 16'h0000;
            cnt    <= 16'h0000;
            state  <= S_RUN;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
          end
        end
        S_RUN: begin
          cnt  <= cnt + 16'd1;
          dcnt <= 3'd0;
          // The last pattern stays on pat through DRAIN, so the LFSR does not step past it.
          if (last_pat) begin
            if (LATENCY == 0) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (misr_nxt == bus.golden);
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            lfsr <= lfsr_nxt;
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + 3'd1;
          if (dcnt == DLAST) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (misr_nxt == bus.golden);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pat  = lfsr[PI_W-1:0];
  assign bus.sig  = misr;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Bench for iscas_bist_ctrl: four instances with different run length / latency, checked against a pattern/signature model.
module tb_iscas_bist_ctrl;

  logic ck = 1'b0;
  logic rn = 1'b1;
  always #5 ck = ~ck;

  iscas_bist_ctrl_if #(.PI_W(3), .PO_W(6)) a_if ();
  iscas_bist_ctrl_if #(.PI_W(3), .PO_W(6)) b_if ();
  iscas_bist_ctrl_if #(.PI_W(3), .PO_W(6)) c_if ();
  iscas_bist_ctrl_if #(.PI_W(3), .PO_W(6)) d_if ();

  iscas_bist_ctrl #(.PI_W(3), .PO_W(6), .N_PAT(4), .LATENCY(1), .SEED(16'hACE1))
    dut_a (.ck(ck), .rn(rn), .bus(a_if));
  iscas_bist_ctrl #(.PI_W(3), .PO_W(6), .N_PAT(1), .LATENCY(0), .SEED(16'hACE1))
    dut_b (.ck(ck), .rn(rn), .bus(b_if));
  iscas_bist_ctrl #(.PI_W(3), .PO_W(6), .N_PAT(256), .LATENCY(1), .SEED(16'hACE1))
    dut_c (.ck(ck), .rn(rn), .bus(c_if));
  iscas_bist_ctrl #(.PI_W(3), .PO_W(6), .N_PAT(64), .LATENCY(3), .SEED(16'hACE1))
    dut_d (.ck(ck), .rn(rn), .bus(d_if));

  // Device model for instance d: its outputs are its inputs delayed by three clocks.
  logic [2:0] d1, d2, d3;
  always @(posedge ck or negedge rn) begin
    if (!rn) begin
      d1 <= 3'b0; d2 <= 3'b0; d3 <= 3'b0;
    end else begin
      d1 <= d_if.pat; d2 <= d1; d3 <= d2;
    end
  end
  assign d_if.po = {3'b000, d3};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] misr_nx(input logic [15:0] m, input logic [15:0] v);
    return {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]} ^ v;
  endfunction

  typedef struct {
    logic [5:0]  po;
    logic [15:0] golden;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t        vt[4];
  logic [2:0]  pats[300];
  logic [5:0]  po_arr[512];
  logic [15:0] l, exp_d, exp_c, sig1;
  int          busy_cnt, first_done, n, cyc, ncap, nz;

  // Expected C signature: pattern k's response is the po driven in cycle k+1 after the start edge.
  function automatic logic [15:0] calc_c();
    logic [15:0] e = 16'h0000;
    for (int k = 0; k < 256; k++) e = misr_nx(e, {10'b0, po_arr[k+1]});
    return e;
  endfunction

  task automatic run_c(input logic [15:0] gold, output int cycles, output int caps, output int nonzero);
    c_if.golden = gold;
    @(negedge ck); c_if.start = 1'b1;
    @(negedge ck); c_if.start = 1'b0;
    chk("c_start_busy", c_if.busy, 1'b1);
    chk("c_start_done", c_if.done, 1'b0);
    cycles = 0; caps = 0; nonzero = 0;
    c_if.po = po_arr[0];
    forever begin
      if (dut_c.cap) caps++;
      if (c_if.sig != 16'h0000) nonzero++;
      if (c_if.done || cycles >= 400) break;
      @(negedge ck);
      cycles++;
      c_if.po = po_arr[cycles];
    end
    chk("c_done", c_if.done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.start = 0; a_if.po = 0; a_if.golden = 0;
    b_if.start = 0; b_if.po = 0; b_if.golden = 0;
    c_if.start = 0; c_if.po = 0; c_if.golden = 0;
    d_if.start = 0; d_if.golden = 0;

    l = 16'hACE1;
    for (int k = 0; k < 300; k++) begin
      pats[k] = l[2:0];
      l = lfsr_nx(l);
    end
    vt[0] = '{po: 6'h01, golden: 16'h0001, exp_sig: 16'h0001, exp_pass: 1'b1};
    vt[1] = '{po: 6'h01, golden: 16'h0002, exp_sig: 16'h0001, exp_pass: 1'b0};
    vt[2] = '{po: 6'h3F, golden: 16'h003F, exp_sig: 16'h003F, exp_pass: 1'b1};
    vt[3] = '{po: 6'h20, golden: 16'h0000, exp_sig: 16'h0020, exp_pass: 1'b0};

    // Reset, then idle with no START
    #3 rn = 1'b0;
    #1;
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_done", a_if.done, 1'b0);
    chk("rst_pass", a_if.pass, 1'b0);
    chk("rst_sig", a_if.sig, 16'h0000);
    chk("rst_pat", a_if.pat, 3'b001);
    repeat (2) @(negedge ck);
    rn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      chk("idle_busy", a_if.busy, 1'b0);
      chk("idle_done", a_if.done, 1'b0);
      chk("idle_sig", a_if.sig, 16'h0000);
      chk("idle_pat", a_if.pat, 3'b001);
    end

    // Pattern sequence and run length: 4 patterns, latency 1
    @(negedge ck); a_if.start = 1'b1;
    @(negedge ck); a_if.start = 1'b0;
    busy_cnt = 0; first_done = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge ck);
      if (a_if.busy) busy_cnt++;
      if (a_if.done && first_done < 0) first_done = c;
      if (c == 0) chk("a_pat0_const", a_if.pat, 3'b001);
      if (c == 1) chk("a_pat1_const", a_if.pat, 3'b000);
      if (c < 4)  chk("a_pat_model", a_if.pat, pats[c]);
      if (c >= 4) chk("a_pat_hold", a_if.pat, pats[3]);
    end
    chk("a_busy_cycles", busy_cnt, 5);
    chk("a_done_cycle", first_done, 5);
    chk("a_sig", a_if.sig, 16'h0000);
    chk("a_pass", a_if.pass, 1'b1);

    // Single-pattern compaction, latency 0, from the vector table
    for (int i = 0; i < 4; i++) begin
      b_if.po = vt[i].po;
      b_if.golden = vt[i].golden;
      @(negedge ck); b_if.start = 1'b1;
      @(negedge ck); b_if.start = 1'b0;
      n = 0;
      while (!b_if.done && n < 20) begin
        @(negedge ck);
        n++;
      end
      chk("b_done", b_if.done, 1'b1);
      chk("b_latency", n, 1);
      chk("b_sig", b_if.sig, vt[i].exp_sig);
      chk("b_pass", b_if.pass, vt[i].exp_pass);
      chk("b_busy", b_if.busy, 1'b0);
    end

    // Latency alignment through the 3-cycle delay device
    exp_d = 16'h0000;
    for (int k = 0; k < 64; k++) exp_d = misr_nx(exp_d, {13'b0, pats[k]});
    d_if.golden = exp_d;
    @(negedge ck); d_if.start = 1'b1;
    @(negedge ck); d_if.start = 1'b0;
    n = 0;
    while (!d_if.done && n < 300) begin
      @(negedge ck);
      n++;
    end
    chk("d_done", d_if.done, 1'b1);
    chk("d_cycles", n, 67);
    chk("d_sig", d_if.sig, exp_d);
    chk("d_pass", d_if.pass, 1'b1);
    repeat (3) @(negedge ck);
    chk("d_sig_stable", d_if.sig, exp_d);

    // Zero response over 256 patterns
    for (int j = 0; j < 512; j++) po_arr[j] = 6'h00;
    run_c(16'h0000, cyc, ncap, nz);
    chk("z_sig", c_if.sig, 16'h0000);
    chk("z_sig_nonzero_cycles", nz, 0);
    chk("z_captures", ncap, 256);
    chk("z_pass", c_if.pass, 1'b1);

    // Random responses against the signature model; second run has a wrong golden
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 512; j++) po_arr[j] = 6'($urandom);
      exp_c = calc_c();
      run_c((r == 0) ? exp_c : (exp_c ^ 16'h0100), cyc, ncap, nz);
      chk("r_sig", c_if.sig, exp_c);
      chk("r_pass", c_if.pass, (r == 0) ? 1'b1 : 1'b0);
      chk("r_captures", ncap, 256);
      chk("r_cycles", cyc, 257);
    end

    // Abort mid-run; START during RUN is ignored
    @(negedge ck); c_if.start = 1'b1;
    @(negedge ck); c_if.start = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge ck);
      c_if.start = (j == 50);
      c_if.po = 6'($urandom);
      if (j == 51) begin
        chk("ab_busy_ignored", c_if.busy, 1'b1);
        chk("ab_pat_ignored", c_if.pat, pats[51]);
      end
    end
    chk("ab_pat100", c_if.pat, pats[100]);
    rn = 1'b0;
    #1;
    chk("ab_busy", c_if.busy, 1'b0);
    chk("ab_done", c_if.done, 1'b0);
    chk("ab_pass", c_if.pass, 1'b0);
    chk("ab_sig", c_if.sig, 16'h0000);
    chk("ab_pat", c_if.pat, 3'b001);

    // START coincident with reset release is dropped
    @(negedge ck);
    rn = 1'b1;
    c_if.start = 1'b1;
    @(negedge ck); c_if.start = 1'b0;
    chk("coinc_busy", c_if.busy, 1'b0);
    @(negedge ck);
    chk("coinc_busy2", c_if.busy, 1'b0);
    chk("coinc_pat", c_if.pat, 3'b001);

    // Restart after DONE reproduces the same signature
    for (int j = 0; j < 512; j++) po_arr[j] = 6'($urandom);
    exp_c = calc_c();
    run_c(exp_c, cyc, ncap, nz);
    sig1 = c_if.sig;
    chk("rs_sig1", sig1, exp_c);
    run_c(exp_c, cyc, ncap, nz);
    chk("rs_sig2", c_if.sig, exp_c);
    chk("rs_repeat", c_if.sig, sig1);
    chk("rs_pass", c_if.pass, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
